// File: rtl/tt_um_pin_fifo.sv
// tt_um_pin_fifo: byte FIFO on the Tiny Tapeout pin frame, push/pop strobes on uio_in; define TT_PIN_FIFO_SYNC_EN to add a 2-flop strobe synchroniser
module tt_um_pin_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] uo_q, uo_d, din;
  logic [1:0]        prev_q, pin;
  logic              push_ev, pop_ev, do_push, do_pop, full;
  logic              unused;
  assign unused = ^{ui_in, uio_in};
`ifdef TT_PIN_FIFO_SYNC_EN
  logic [1:0] s1_q, s2_q;
  // two-flop synchroniser, reset high so a held pin does not fire on release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= uio_in[1:0];
      s2_q <= s1_q;
    end
  assign pin = s2_q;
`else
  assign pin = uio_in[1:0];
`endif
  // edge detection, pointer/count next state and show-ahead head selection
  always_comb begin
    din     = ui_in[DATA_W-1:0];
    full    = cnt_q == 5'(DEPTH);
    push_ev = ena & pin[0] & ~prev_q[0];
    pop_ev  = ena & pin[1] & ~prev_q[1];
    do_pop  = pop_ev & (cnt_q != 5'd0);
    do_push = push_ev & (~full | do_pop);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + 5'(do_push) - 5'(do_pop);
    uo_d    = cnt_d == 5'd0 ? '0 : (do_push && wr_q == rd_d) ? din : mem_q[rd_d];
  end
  // storage array; contents are not reset
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  // control state; history updates every cycle even while disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      uo_q   <= '0;
      prev_q <= 2'b11;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      uo_q   <= uo_d;
      prev_q <= pin;
    end
  assign uo_out  = 8'(uo_q);
  assign uio_out = {cnt_q, full, 2'b00};
  assign uio_oe  = 8'hFC;
endmodule

// File: tb/tb_tt_um_pin_fifo.sv
// tb_tt_um_pin_fifo: scoreboard bench for the pin FIFO at DATA_W 8 and 4
module tb_tt_um_pin_fifo;
  logic       clk = 0, rst = 1, ena = 1;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe, uo_out4, uio_out4, uio_oe4;
  int n_chk = 0, n_fail = 0;
  typedef struct {string nm; int uo; int cnt;} exp_t;
  exp_t sb[$];
  byte  mdl[$];

  tt_um_pin_fifo u_dut (.clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
                        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe));
  tt_um_pin_fifo #(.DATA_W(4)) u_dut4 (.clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out4),
                        .uio_in(uio_in), .uio_out(uio_out4), .uio_oe(uio_oe4));

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic expect_state(string nm);
    exp_t e;
    e.nm  = nm;
    e.cnt = mdl.size();
    e.uo  = mdl.size() != 0 ? int'(mdl[0]) & 8'hFF : 0;
    sb.push_back(e);
  endtask

  task automatic expect_raw(string nm, int uo, int cnt);
    exp_t e;
    e.nm = nm; e.uo = uo; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic op(bit push, bit pop, byte data, string nm);
    bit dp, dq;
    @(posedge clk); #1;
    ui_in  = data;
    uio_in = {6'b0, pop, push};
    @(posedge clk); #1;
    uio_in = 0;
    if (ena) begin
      dp = pop && mdl.size() != 0;
      dq = push && (mdl.size() < 8 || dp);
      if (dp) void'(mdl.pop_front());
      if (dq) mdl.push_back(data);
    end
    expect_state(nm);
  endtask

  // monitor: compare both instances against the oldest expectation
  always @(negedge clk)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, " uo_out"},  uo_out,       e.uo);
      chk({e.nm, " uo_out4"}, uo_out4,      e.uo & 8'h0F);
      chk({e.nm, " count"},   uio_out[7:3], e.cnt);
      chk({e.nm, " count4"},  uio_out4[7:3], e.cnt);
      chk({e.nm, " full"},    uio_out[2],   e.cnt == 8);
      chk({e.nm, " low"},     uio_out[1:0], 0);
      chk({e.nm, " oe"},      uio_oe,       8'hFC);
    end

  initial begin
    uio_in = 8'h01;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (5) @(posedge clk);
    #1 expect_raw("reset_held_push", 0, 0);
    uio_in = 0;
    op(1, 0, 8'hA5, "push_a5");
    op(1, 0, 8'h3C, "push_3c");
    op(0, 1, 8'h00, "pop_a5");
    op(0, 1, 8'h00, "pop_3c");
    for (int i = 1; i <= 8; i++) op(1, 0, byte'(i), "fill");
    expect_raw("full_hand", 8'h01, 8);
    op(1, 0, 8'hFF, "overflow");
    for (int i = 0; i < 8; i++) op(0, 1, 8'h00, "drain");
    expect_raw("empty_hand", 0, 0);
    op(1, 1, 8'h55, "both_empty");
    expect_raw("both_empty_hand", 8'h55, 1);
    op(0, 1, 8'h00, "pop_55");
    for (int i = 0; i < 8; i++) op(1, 0, byte'(8'h10 + i), "fill2");
    op(1, 1, 8'h99, "both_full");
    expect_raw("both_full_hand", 8'h11, 8);
    for (int i = 0; i < 8; i++) op(0, 1, 8'h00, "drain2");
    ena = 0;
    for (int i = 0; i < 3; i++) op(1, 0, 8'h77, "ena_low_push");
    @(posedge clk); #1 uio_in = 8'h01;
    @(posedge clk); #1 ena = 1;
    repeat (3) @(posedge clk);
    #1 expect_raw("ena_rise_held", 0, 0);
    uio_in = 0;
    op(1, 0, 8'h5A, "push_after_ena");
    op(0, 1, 8'h00, "pop_5a");
    op(1, 0, 8'hF7, "push_f7");
    op(0, 1, 8'h00, "pop_f7");
    op(0, 1, 8'h00, "underflow");
    op(1, 0, 8'h42, "push_42");
    op(0, 1, 8'h00, "pop_42");
    op(1, 0, 8'h21, "pre_rst_a");
    op(1, 0, 8'h22, "pre_rst_b");
    @(posedge clk); #3 rst = 1;
    mdl.delete();
    expect_state("async_reset");
    @(posedge clk); #1 rst = 0;
    op(1, 0, 8'h63, "post_rst_push");
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
